// File: rtl/axi_wr_slave.sv
// -----------------------------------------------------------------------------
// axi_wr_slave
//
// AXI4 write-channel slave. Accepts one AW burst at a time, consumes its W
// beats and re-issues each beat as an address/data/strobe transfer on a simple
// valid/ready stream toward the downstream register/memory stage. One B
// response per burst echoes the AWID. Read channels live in a separate block.
//
// Ports
//   s_axi_aclk, s_axi_areset     clock, synchronous active-high reset
//   s_axi_aw*                    write address channel (awuser is ignored)
//   s_axi_w*                     write data channel
//   s_axi_b*                     write response channel (OKAY / SLVERR)
//   wr_addr/wr_data/wr_strb      downstream beat payload
//   wr_valid/wr_ready            downstream beat handshake
// -----------------------------------------------------------------------------
module axi_wr_slave #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 128,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
  parameter int AXI_STROBE_LEN   = $clog2(AXI_STROBE_WIDTH)
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,

  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [15:0]                 s_axi_awid,
  input  logic [1:0]                  s_axi_awburst,
  input  logic [2:0]                  s_axi_awsize,
  input  logic [7:0]                  s_axi_awlen,
  input  logic [15:0]                 s_axi_awuser,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,

  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_STROBE_WIDTH-1:0] s_axi_wstrb,
  input  logic                        s_axi_wlast,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,

  output logic [15:0]                 s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,

  output logic [AXI_ADDR_WIDTH-1:0]   wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]   wr_data,
  output logic [AXI_STROBE_WIDTH-1:0] wr_strb,
  output logic                        wr_valid,
  input  logic                        wr_ready
);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] MAX_SIZE    = 3'(AXI_STROBE_LEN);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] beat_addr;
  logic [15:0]               id_q;
  logic [1:0]                burst_q;
  logic [2:0]                size_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_cnt;
  // drop_err: burst type/size cannot be decoded, so beats are swallowed.
  // resp_err: a wlast mismatch was seen; beats are still forwarded, only the
  // response turns into SLVERR.
  logic                      drop_err;
  logic                      resp_err;

  logic                      w_hs;
  logic                      last_beat;
  logic                      wlast_bad;
  logic [AXI_ADDR_WIDTH-1:0] addr_step;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;

  // awuser carries nothing this block needs.
  logic unused_awuser;
  assign unused_awuser = ^s_axi_awuser;

  // NOTE: continuous assigns cannot hold state, so this ready path is purely
  // combinational and infers no latch. The single-entry output register can
  // take a new beat when it is empty or being drained this cycle; a dropping
  // burst never touches it and so is always ready.
  assign s_axi_wready = (state == DATA) && (drop_err || !wr_valid || wr_ready);

  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign last_beat = (beat_cnt == len_q);
  assign wlast_bad = s_axi_wlast ^ last_beat;
  assign addr_step = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
  // FIXED repeats the start address; INCR wraps naturally at 2^AXI_ADDR_WIDTH.
  assign next_addr = (burst_q == BURST_INCR) ? beat_addr + addr_step : beat_addr;

  // NOTE: every register here is assigned with <= so all state updates take
  // effect together at the clock edge, independent of statement order.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state         <= IDLE;
      s_axi_awready <= 1'b1;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      wr_valid      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_strb       <= '0;
      beat_addr     <= '0;
      id_q          <= '0;
      burst_q       <= '0;
      size_q        <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
      drop_err      <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      // Downstream output register: load on an accepted beat, otherwise
      // clear once the consumer has taken the current one.
      if (w_hs && !drop_err) begin
        wr_valid <= 1'b1;
        wr_addr  <= beat_addr;
        wr_data  <= s_axi_wdata;
        wr_strb  <= s_axi_wstrb;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            beat_addr     <= s_axi_awaddr;
            id_q          <= s_axi_awid;
            burst_q       <= s_axi_awburst;
            size_q        <= s_axi_awsize;
            len_q         <= s_axi_awlen;
            beat_cnt      <= '0;
            drop_err      <= s_axi_awburst[1] || (s_axi_awsize > MAX_SIZE);
            resp_err      <= 1'b0;
            s_axi_awready <= 1'b0;
            state         <= DATA;
          end
        end

        DATA: begin
          if (w_hs) begin
            beat_cnt  <= beat_cnt + 8'd1;
            beat_addr <= next_addr;
            if (wlast_bad) begin
              resp_err <= 1'b1;
            end
            // Burst length is fixed by awlen; wlast only affects the response.
            if (last_beat) begin
              state        <= RESP;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= id_q;
              s_axi_bresp  <= (drop_err || resp_err || wlast_bad) ? RESP_SLVERR
                                                                  : RESP_OKAY;
            end
          end
        end

        RESP: begin
          if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          s_axi_awready <= 1'b1;
          s_axi_bvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
